fp_operand_loader: RTL and testbench
====================================

# fp_operand_loader

Upstream feeder for the floating-point adder. Receives a byte stream over a valid/ready handshake and assembles two 32-bit operands (sign, 6-bit exponent, 25-bit mantissa; bit 0 = MSB). It applies both operands to the adder atomically and holds them stable for a programmable settle window. It then captures the adder's `data_out`/`status_out` and presents them as a result under a second valid/ready handshake.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 80: clock cycles between operand apply and result capture. Legal range 1..255. Must cover at least two worst-case adder iterations, because the adder free-runs and may be mid-iteration when the operands change.

Ports:
- `clock_100kHz`  in  1  system clock, rising-edge active
- `reset`  in  1  asynchronous, active-low
- `byte_in`  in  8  operand byte, MSB-first within each operand
- `byte_valid`  in  1  `byte_in` valid
- `byte_ready`  out  1  loader accepts a byte this cycle
- `op_A_out`  out  [0:31]  operand A to the adder
- `op_B_out`  out  [0:31]  operand B to the adder
- `sum_in`  in  [0:31]  adder `data_out`
- `status_in`  in  [0:3]  adder status: 0 exact, 1 overflow, 2 underflow, 3 inexact
- `result_out`  out  [0:31]  captured sum
- `result_status`  out  [0:3]  captured status
- `result_valid`  out  1  result available
- `result_ready`  in  1  consumer takes the result
- `busy`  out  1  high in APPLY, SETTLE and PRESENT

## Operation
**States:** LOAD, APPLY, SETTLE, PRESENT. Reset state is LOAD.

**LOAD**
- `byte_ready` = 1.
- A transfer occurs on an edge with `byte_valid && byte_ready`.
- A 3-bit byte counter selects the destination in shadow registers:
  - bytes 0..3 fill A[0:7], A[8:15], A[16:23], A[24:31];
  - bytes 4..7 fill B in the same order.
- The transfer at count 7 wraps the counter to 0 and moves the FSM to APPLY.
- Cycles with `byte_valid` low leave the counter unchanged. Gaps are legal.

**APPLY**
- One cycle.
- Copies both shadow registers to `op_A_out`/`op_B_out` on the same edge.
- Clears the settle counter and moves to SETTLE.

**SETTLE**
- The 8-bit counter increments every cycle.
- On the edge where the counter reaches `SETTLE_CYCLES-1`:
  - `sum_in` → `result_out`, `status_in` → `result_status`;
  - `result_valid` is set and the FSM moves to PRESENT.
- `sum_in`/`status_in` values on all other cycles are ignored.

**PRESENT**
- `result_valid` = 1, and the result registers are held stable.
- When `result_ready` is high on an edge: clear `result_valid`, then move to LOAD.

**General rules**
- `op_A_out`/`op_B_out` change only in APPLY. They hold their values through PRESENT and the next LOAD.
- No operand is ever partially updated.
- `byte_ready` = 0 outside LOAD. `byte_valid` is ignored there and no byte is consumed.
- Reset at any point:
  - FSM → LOAD, byte and settle counters → 0;
  - partial frame discarded, shadow registers → 0.

## Timing
**Reset values**
- `byte_ready` 0, `op_A_out` 0, `op_B_out` 0, `result_out` 0, `result_status` 0, `result_valid` 0, `busy` 0.
- `byte_ready` rises at the first rising edge after `reset` deasserts.

**Latency**
- 8th byte handshake at edge k:
  - `op_*_out` update at edge k+1;
  - result captured, `result_valid` = 1 at edge k+1+`SETTLE_CYCLES`.
- Result accepted at edge m: `byte_ready` = 1 after edge m, and the next byte can be accepted at edge m+1.

**Throughput:** minimum 8 + 1 + `SETTLE_CYCLES` + 1 cycles per operation.

**Handshake**
- If `result_ready` is held high in advance, `result_valid` is a one-cycle pulse.
- `result_valid` never drops without a handshake, except on reset.

**Registering:** all outputs are registered except `byte_ready` and `busy`, which decode directly from the state register.

## Test plan
- **Reset:** assert `reset`=0 mid-SETTLE → all outputs 0 immediately. After release, `byte_ready`=1 from the first edge.
- **Basic frame:** bytes 40 00 00 00 20 00 00 00 with back-to-back valid.
  - `op_A_out`=32'h40000000 and `op_B_out`=32'h20000000 appear exactly one edge after the 8th byte, and are unchanged before it.
  - Stub `sum_in`=32'h41000000, `status_in`=0 → `result_out`=32'h41000000, `result_status`=0.
  - `result_valid` rises 81 edges after the 8th byte.
- **Backpressure:** hold `result_ready`=0 for 10 cycles in PRESENT while driving `byte_valid`=1.
  - `result_valid` stays 1 and `byte_ready` stays 0.
  - No byte is consumed and the result is stable.
  - Next frame loads correctly.
- **Gapped input:** `byte_valid` alternates 1/0 with bytes 80 01 02 03 7F FF FF FF → `op_A_out`=32'h80010203, `op_B_out`=32'h7FFFFFFF.
- **Reset mid-frame:** reset after 5 bytes → partial frame discarded. A fresh 8-byte frame yields the correct operands, with no leftover bytes shifted in.
- **Capture window:** stub changes `sum_in` every cycle and sets `status_in`=1 only on the capture cycle → result equals the capture-cycle values and `result_status`=1.

Source files
------------

// File: rtl/fp_operand_loader_if.sv
// Bus bundle between the byte/result side of the system and the FP operand loader.
// Bit 0 is the MSB of every operand, sum and status field.
interface fp_operand_loader_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [0:31] op_A_out;
   logic [0:31] op_B_out;
   logic [0:31] sum_in;
   logic [0:3]  status_in;
   logic [0:31] result_out;
   logic [0:3]  result_status;
   logic        result_valid;
   logic        result_ready;
   logic        busy;

   modport slave (
      input  byte_in, byte_valid, sum_in, status_in, result_ready,
      output byte_ready, op_A_out, op_B_out, result_out, result_status, result_valid, busy
   );

   modport master (
      output byte_in, byte_valid, sum_in, status_in, result_ready,
      input  byte_ready, op_A_out, op_B_out, result_out, result_status, result_valid, busy
   );
endinterface

// File: rtl/fp_operand_loader.sv
// Assembles two 32-bit operands from a byte stream, applies them to the free-running adder
// atomically, waits a settle window, then presents the captured sum under valid/ready.
module fp_operand_loader #(
   parameter int unsigned SETTLE_CYCLES = 80
) (
   input  logic               clock_100kHz,
   input  logic               reset,
   fp_operand_loader_if.slave bus
);

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      APPLY   = 2'd1,
      SETTLE  = 2'd2,
      PRESENT = 2'd3
   } state_e;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_e      state_q, state_d;
   logic        armed_q;
   logic [2:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  settle_cnt_q, settle_cnt_d;
   logic [0:31] shadow_a_q, shadow_a_d;
   logic [0:31] shadow_b_q, shadow_b_d;
   logic [0:31] op_a_q, op_a_d;
   logic [0:31] op_b_q, op_b_d;
   logic [0:31] result_q, result_d;
   logic [0:3]  status_q, status_d;
   logic        result_valid_q, result_valid_d;
   logic        byte_fire;
   logic [4:0]  byte_lane;

   // armed_q keeps byte_ready low while reset is held, yet lets it rise on the first edge after.
   assign bus.byte_ready    = armed_q && (state_q == LOAD);
   assign bus.busy          = (state_q != LOAD);
   assign bus.op_A_out      = op_a_q;
   assign bus.op_B_out      = op_b_q;
   assign bus.result_out    = result_q;
   assign bus.result_status = status_q;
   assign bus.result_valid  = result_valid_q;

   assign byte_fire = bus.byte_valid && bus.byte_ready;
   assign byte_lane = {byte_cnt_q[1:0], 3'b000};

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path can infer a latch.
      state_d        = state_q;
      byte_cnt_d     = byte_cnt_q;
      settle_cnt_d   = settle_cnt_q;
      shadow_a_d     = shadow_a_q;
      shadow_b_d     = shadow_b_q;
      op_a_d         = op_a_q;
      op_b_d         = op_b_q;
      result_d       = result_q;
      status_d       = status_q;
      result_valid_d = result_valid_q;

      unique case (state_q)
         LOAD: begin
            if (byte_fire) begin
               if (byte_cnt_q[2]) shadow_b_d[byte_lane +: 8] = bus.byte_in;
               else               shadow_a_d[byte_lane +: 8] = bus.byte_in;
               byte_cnt_d = byte_cnt_q + 3'd1;
               if (byte_cnt_q == 3'd7) state_d = APPLY;
            end
         end
         APPLY: begin
            op_a_d       = shadow_a_q;
            op_b_d       = shadow_b_q;
            settle_cnt_d = 8'd0;
            state_d      = SETTLE;
         end
         SETTLE: begin
            settle_cnt_d = settle_cnt_q + 8'd1;
            // The adder output is only trusted at the end of the window.
            if (settle_cnt_q == SETTLE_LAST) begin
               result_d       = bus.sum_in;
               status_d       = bus.status_in;
               result_valid_d = 1'b1;
               state_d        = PRESENT;
            end
         end
         PRESENT: begin
            if (bus.result_ready) begin
               result_valid_d = 1'b0;
               state_d        = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clock_100kHz or negedge reset) begin
      if (!reset) begin
         state_q        <= LOAD;
         armed_q        <= 1'b0;
         byte_cnt_q     <= '0;
         settle_cnt_q   <= '0;
         shadow_a_q     <= '0;
         shadow_b_q     <= '0;
         op_a_q         <= '0;
         op_b_q         <= '0;
         result_q       <= '0;
         status_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values together.
         state_q        <= state_d;
         armed_q        <= 1'b1;
         byte_cnt_q     <= byte_cnt_d;
         settle_cnt_q   <= settle_cnt_d;
         shadow_a_q     <= shadow_a_d;
         shadow_b_q     <= shadow_b_d;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         result_q       <= result_d;
         status_q       <= status_d;
         result_valid_q <= result_valid_d;
      end
   end

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed-plus-random bench for fp_operand_loader; expectations come from a frame-level model
// (operands are byte concatenations, result is whatever the adder drove on the capture edge).
`timescale 1ns/1ps
module tb_fp_operand_loader;

   localparam int S = 80;

   logic clock_100kHz = 1'b0;
   logic reset        = 1'b0;

   fp_operand_loader_if bus();

   fp_operand_loader #(.SETTLE_CYCLES(S)) dut (
      .clock_100kHz (clock_100kHz),
      .reset        (reset),
      .bus          (bus)
   );

   always #5 clock_100kHz = ~clock_100kHz;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [31:0] model_a = '0;
   logic [31:0] model_b = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_100kHz);
      #1;
   endtask

   function automatic logic [7:0] byte_of(input logic [31:0] a, input logic [31:0] b, input int i);
      logic [31:0] w;
      w = (i < 4) ? a : b;
      return 8'(w >> (24 - 8 * (i % 4)));
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_op_a"},    bus.op_A_out, 32'd0);
      check({tag, "_op_b"},    bus.op_B_out, 32'd0);
      check({tag, "_result"},  bus.result_out, 32'd0);
      check({tag, "_status"},  32'(bus.result_status), 32'd0);
      check({tag, "_valid"},   32'(bus.result_valid), 32'd0);
      check({tag, "_ready"},   32'(bus.byte_ready), 32'd0);
      check({tag, "_busy"},    32'(bus.busy), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] v);
      int w;
      w = 0;
      bus.byte_valid = 1'b1;
      bus.byte_in    = v;
      while (!bus.byte_ready && w < 200) begin
         tick();
         w++;
      end
      check("byte_ready_wait", 32'(bus.byte_ready), 32'd1);
      tick();
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
   endtask

   // Ends just after the edge that took the 8th byte; operands must not have moved yet.
   task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input int gap_mode);
      int gaps;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            check("op_a_before_last", bus.op_A_out, model_a);
            check("op_b_before_last", bus.op_B_out, model_b);
         end
         send_byte(byte_of(a, b, i));
         if (i < 7) begin
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            repeat (gaps) tick();
         end
      end
      check("op_a_hold_at_last", bus.op_A_out, model_a);
      check("ready_low_apply", 32'(bus.byte_ready), 32'd0);
      check("busy_apply", 32'(bus.busy), 32'd1);
   endtask

   // sum_mode: 0 fixed stub 41000000/exact, 1 random sum with status 1 only on capture edge, 2 random.
   task automatic settle_and_capture(input logic [31:0] a, input logic [31:0] b,
                                     input int sum_mode, input int hold);
      logic [31:0] drv_sum;
      logic [3:0]  drv_st;
      int          n;
      tick();
      check("op_a_applied", bus.op_A_out, a);
      check("op_b_applied", bus.op_B_out, b);
      model_a = a;
      model_b = b;
      bus.result_ready = (hold == 0);
      n = 0;
      do begin
         n++;
         case (sum_mode)
            0:       begin drv_sum = 32'h4100_0000; drv_st = 4'd0; end
            1:       begin drv_sum = $urandom; drv_st = (n == S) ? 4'd1 : 4'd0; end
            default: begin drv_sum = $urandom; drv_st = 4'($urandom_range(0, 15)); end
         endcase
         bus.sum_in    = drv_sum;
         bus.status_in = drv_st;
         tick();
      end while (!bus.result_valid && n < S + 50);
      check("settle_edges", 32'(n), 32'(S));
      check("result_out", bus.result_out, drv_sum);
      check("result_status", 32'(bus.result_status), 32'(drv_st));
      check("busy_present", 32'(bus.busy), 32'd1);
      bus.sum_in    = $urandom;
      bus.status_in = 4'($urandom_range(0, 15));
      if (hold > 0) begin
         bus.byte_valid = 1'b1;
         bus.byte_in    = 8'($urandom);
         repeat (hold) begin
            tick();
            check("bp_valid_held", 32'(bus.result_valid), 32'd1);
            check("bp_ready_low", 32'(bus.byte_ready), 32'd0);
            check("bp_result_stable", bus.result_out, drv_sum);
            check("bp_status_stable", 32'(bus.result_status), 32'(drv_st));
         end
         bus.byte_valid   = 1'b0;
         bus.result_ready = 1'b1;
      end
      tick();
      check("valid_cleared", 32'(bus.result_valid), 32'd0);
      check("ready_after_accept", 32'(bus.byte_ready), 32'd1);
      check("op_a_kept_in_load", bus.op_A_out, model_a);
      bus.result_ready = 1'b0;
   endtask

   // Asserts reset mid-cycle, checks outputs clear without waiting for an edge, then releases.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #2;
      check_all_zero(tag);
      bus.byte_valid   = 1'b0;
      bus.result_ready = 1'b0;
      model_a = '0;
      model_b = '0;
      @(negedge clock_100kHz);
      @(negedge clock_100kHz);
      reset = 1'b1;
      #1;
      check("ready_before_first_edge", 32'(bus.byte_ready), 32'd0);
      tick();
      check("ready_after_first_edge", 32'(bus.byte_ready), 32'd1);
      check("busy_in_load", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [31:0] a, b;
      bus.byte_in      = '0;
      bus.byte_valid   = 1'b0;
      bus.sum_in       = '0;
      bus.status_in    = '0;
      bus.result_ready = 1'b0;

      // Power-on reset values.
      #3;
      check_all_zero("por");
      @(negedge clock_100kHz);
      reset = 1'b1;
      #1;
      check("por_ready_before_edge", 32'(bus.byte_ready), 32'd0);
      tick();
      check("por_ready_after_edge", 32'(bus.byte_ready), 32'd1);

      // Basic frame with a fixed adder stub.
      send_frame(32'h4000_0000, 32'h2000_0000, 0);
      settle_and_capture(32'h4000_0000, 32'h2000_0000, 0, 0);

      // Backpressure while bytes are offered, then a frame that must load cleanly.
      a = $urandom; b = $urandom;
      send_frame(a, b, 0);
      settle_and_capture(a, b, 2, 10);
      a = $urandom; b = $urandom;
      send_frame(a, b, 0);
      settle_and_capture(a, b, 2, 0);

      // Gapped input.
      send_frame(32'h8001_0203, 32'h7FFF_FFFF, 1);
      settle_and_capture(32'h8001_0203, 32'h7FFF_FFFF, 2, 0);

      // Capture window: status is 1 only on the capture edge.
      a = $urandom; b = $urandom;
      send_frame(a, b, 0);
      settle_and_capture(a, b, 1, 0);

      // Reset after five bytes; a fresh frame must not contain leftovers.
      a = $urandom; b = $urandom;
      for (int i = 0; i < 5; i++) send_byte(byte_of(a, b, i));
      do_reset("rst_mid_frame");
      a = $urandom; b = $urandom;
      send_frame(a, b, 2);
      settle_and_capture(a, b, 2, 0);

      // Reset in the middle of SETTLE.
      a = $urandom; b = $urandom;
      send_frame(a, b, 0);
      tick();
      check("op_a_before_settle_rst", bus.op_A_out, a);
      repeat (20) tick();
      check("busy_mid_settle", 32'(bus.busy), 32'd1);
      do_reset("rst_mid_settle");

      // Randomized frames with random gaps, modes and backpressure.
      for (int f = 0; f < 3; f++) begin
         a = $urandom; b = $urandom;
         send_frame(a, b, 2);
         settle_and_capture(a, b, int'($urandom_range(1, 2)), int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
